usb2_tx_data_pkt: RTL

- Device-side IN-transaction packet transmitter; the consumer end of the endpoint buffer read interface exposed by the protocol layer.
- On an IN token for a selected endpoint, it either sends NAK or reads the armed buffer and streams PID + payload + CRC16 as bytes to the PHY transmit port.
- It then waits for the host handshake and, on ACK, flips the data toggle and re-arms the buffer.

---
 rtl/usb2_tx_data_pkt.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/usb2_tx_data_pkt.sv
// IN-transaction transmitter: answers an IN token with NAK or PID + payload + CRC16,
// then waits for the host ACK to advance the data toggle and re-arm the endpoint buffer.
module usb2_tx_data_pkt #(
  parameter int MAX_PKT     = 512,
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic       phy_clk,
  input  logic       reset_n,
  input  logic       in_token,
  input  logic [3:0] in_endp,
  input  logic       host_ack,
  output logic [3:0] sel_endp,
  output logic [8:0] buf_out_addr,
  input  logic [7:0] buf_out_q,
  input  logic [9:0] buf_out_len,
  input  logic       buf_out_hasdata,
  output logic       buf_out_arm,
  input  logic       buf_out_arm_ack,
  input  logic [1:0] data_toggle,
  output logic       data_toggle_act,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       tx_done
);

  // Handshake: a byte moves to the PHY in every cycle where tx_valid && tx_ready;
  // while tx_valid && !tx_ready, tx_data and tx_valid hold their values.

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_NAK, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_WAIT_ACK, S_ARM
  } state_t;

  localparam int             TW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0]  TO_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [9:0]     MAX_LEN  = 10'(MAX_PKT);
  localparam logic [7:0]     PID_NAK  = 8'h5A;
  localparam logic [7:0]     PID_D0   = 8'hC3;
  localparam logic [7:0]     PID_D1   = 8'h4B;

  state_t        state_q, state_d;
  logic [3:0]    sel_endp_q, sel_endp_d;
  logic [9:0]    len_q, len_d;
  logic [9:0]    cnt_q, cnt_d;
  logic [8:0]    nxt_q, nxt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic [15:0]   crc_q, crc_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          arm_q, arm_d;
  logic          toggle_act_q, toggle_act_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          xfer;
  logic [15:0]   crc_upd;
  logic          unused_toggle_hi;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  assign xfer             = tx_valid_q & tx_ready;
  assign crc_upd          = crc16_byte(crc_q, tx_data_q);
  assign unused_toggle_hi = data_toggle[1];

  always_comb begin
    state_d      = state_q;
    sel_endp_d   = sel_endp_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    nxt_d        = nxt_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    crc_d        = crc_q;
    to_cnt_d     = to_cnt_q;
    arm_d        = arm_q;
    toggle_act_d = 1'b0;
    done_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_token) begin
          sel_endp_d = in_endp;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!buf_out_hasdata) begin
          tx_data_d  = PID_NAK;
          tx_valid_d = 1'b1;
          state_d    = S_NAK;
        end else begin
          len_d      = (buf_out_len > MAX_LEN) ? MAX_LEN : buf_out_len;
          cnt_d      = '0;
          nxt_d      = '0;
          crc_d      = 16'hFFFF;
          tx_data_d  = data_toggle[0] ? PID_D1 : PID_D0;
          tx_valid_d = 1'b1;
          state_d    = S_PID;
        end
      end
      S_NAK: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_PID: begin
        // buf_out_q already carries byte 0, so DATA starts without a bubble.
        if (xfer) begin
          cnt_d = '0;
          if (len_q != 10'd0) begin
            tx_data_d = buf_out_q;
            if (len_q > 10'd1) nxt_d = 9'd1;
            state_d = S_DATA;
          end else begin
            tx_data_d = ~crc_q[7:0];
            state_d   = S_CRC_LO;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          crc_d = crc_upd;
          if (cnt_q == len_q - 10'd1) begin
            tx_data_d = ~crc_upd[7:0];
            state_d   = S_CRC_LO;
          end else begin
            tx_data_d = buf_out_q;
            cnt_d     = cnt_q + 10'd1;
            // Fetch stops at len-1, so a 512-byte packet never wraps to address 0.
            if ({1'b0, nxt_q} < len_q - 10'd1) nxt_d = nxt_q + 9'd1;
          end
        end
      end
      S_CRC_LO: begin
        if (xfer) begin
          tx_data_d = ~crc_q[15:8];
          state_d   = S_CRC_HI;
        end
      end
      S_CRC_HI: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
          to_cnt_d   = '0;
          state_d    = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (host_ack) begin
          toggle_act_d = 1'b1;
          arm_d        = 1'b1;
          state_d      = S_ARM;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_ARM: begin
        if (buf_out_arm_ack) begin
          arm_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      sel_endp_q   <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      nxt_q        <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      crc_q        <= 16'hFFFF;
      to_cnt_q     <= '0;
      arm_q        <= 1'b0;
      toggle_act_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_endp_q   <= sel_endp_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      nxt_q        <= nxt_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      crc_q        <= crc_d;
      to_cnt_q     <= to_cnt_d;
      arm_q        <= arm_d;
      toggle_act_q <= toggle_act_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  // The address is the fetch that lands on buf_out_q next cycle.
  assign buf_out_addr    = nxt_d;
  assign sel_endp        = sel_endp_q;
  assign tx_data         = tx_data_q;
  assign tx_valid        = tx_valid_q;
  assign buf_out_arm     = arm_q;
  assign data_toggle_act = toggle_act_q;
  assign tx_done         = done_q;
  assign busy            = busy_q;

endmodule
